// File: rtl/vram_port_arb.sv
// VRAM port A arbiter and fill sequencer.
// Shares one VRAM write/read port between single-byte CPU accesses and a
// constant-colour fill engine. Port B (display scan-out) is not touched here.
//
// CPU handshake: i_cpu_req is raised with i_cpu_we/i_cpu_addr/i_cpu_wdata
// stable and held until o_cpu_ack pulses for one cycle. The request is only
// sampled in IDLE or FILL, so keeping it high through the ack cycle never
// starts a duplicate access.
module vram_port_arb #(
    parameter int unsigned VRAM_WORDS = 327680,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [18:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    input  logic        i_fill_start,
    input  logic [18:0] i_fill_base,
    input  logic [18:0] i_fill_len,
    input  logic [7:0]  i_fill_color,
    output logic        o_fill_busy,
    output logic        o_fill_done,
    output logic [18:0] o_vram_addra,
    output logic [7:0]  o_vram_dina,
    output logic        o_vram_wea,
    input  logic [7:0]  i_vram_douta,
    output logic [2:0]  o_dbg_state
);

    localparam logic [18:0] LP_LIMIT = 19'(VRAM_WORDS);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] LP_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [SW-1:0] LP_STARVE_ONE = SW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_ACC = 3'd1,
        ST_CPU_RD  = 3'd2,
        ST_CPU_ACK = 3'd3,
        ST_FILL    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_grant;

    logic          r_cpu_we;
    logic [18:0]   r_cpu_addr;
    logic [7:0]    r_cpu_wdata;
    logic [7:0]    r_cpu_rdata;

    logic          r_fill_busy;
    logic          r_fill_done;
    logic [18:0]   r_ptr;
    logic [18:0]   r_remain;
    logic [7:0]    r_fill_color;
    logic [SW-1:0] r_starve;

    logic [18:0]   r_port_addr;
    logic [7:0]    r_port_din;

    logic          w_cpu_in_range;
    logic          w_fill_write;
    logic          w_fill_empty;
    logic          w_fill_end;
    logic          w_cpu_blocked;
    logic [18:0]   w_addra;
    logic [7:0]    w_dina;
    logic          w_wea;

    assign w_cpu_in_range = (r_cpu_addr < LP_LIMIT);

    // A fill write happens only in FILL with bytes left and an in-range pointer.
    assign w_fill_write = (r_state == ST_FILL) && r_fill_busy &&
                          (r_remain != 19'd0) && (r_ptr < LP_LIMIT);

    // Zero-length or out-of-range launches end without writing anything.
    assign w_fill_empty = r_fill_busy &&
                          ((r_remain == 19'd0) || (r_ptr >= LP_LIMIT));

    // End on the last byte, or on the last in-range address (clip).
    assign w_fill_end = w_fill_empty ||
                        (w_fill_write && ((r_remain == 19'd1) ||
                                          (r_ptr == LP_LIMIT - 19'd1)));

    // A fill write in this cycle clears the starve count, so the CPU may be
    // granted alongside it; otherwise a full count holds the CPU off.
    assign w_cpu_blocked = (r_starve >= LP_STARVE_MAX) && !w_fill_write;

    // Next-state and grant decision.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cpu_req && !w_cpu_blocked) begin
                    w_grant = 1'b1;
                    w_next  = ST_CPU_ACC;
                end else if (r_fill_busy) begin
                    w_next = ST_FILL;
                end
            end
            ST_CPU_ACC: w_next = r_cpu_we ? ST_CPU_ACK : ST_CPU_RD;
            ST_CPU_RD:  w_next = ST_CPU_ACK;
            ST_CPU_ACK: w_next = ST_IDLE;
            ST_FILL: begin
                if (i_cpu_req && !w_cpu_blocked) begin
                    w_grant = 1'b1;
                    w_next  = ST_CPU_ACC;
                end else if (!r_fill_busy || w_fill_end) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Latch the CPU request on grant; capture read data in CPU_RD.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cpu_we    <= 1'b0;
            r_cpu_addr  <= 19'd0;
            r_cpu_wdata <= 8'd0;
            r_cpu_rdata <= 8'd0;
        end else begin
            if (w_grant) begin
                r_cpu_we    <= i_cpu_we;
                r_cpu_addr  <= i_cpu_addr;
                r_cpu_wdata <= i_cpu_wdata;
            end
            if (r_state == ST_CPU_RD)
                r_cpu_rdata <= w_cpu_in_range ? i_vram_douta : 8'h00;
        end
    end

    // Fill launch, pointer/remaining update and completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fill_busy  <= 1'b0;
            r_fill_done  <= 1'b0;
            r_ptr        <= 19'd0;
            r_remain     <= 19'd0;
            r_fill_color <= 8'd0;
        end else begin
            r_fill_done <= 1'b0;
            if (!r_fill_busy) begin
                if (i_fill_start) begin
                    r_fill_busy  <= 1'b1;
                    r_ptr        <= i_fill_base;
                    r_remain     <= i_fill_len;
                    r_fill_color <= i_fill_color;
                end
            end else begin
                if (w_fill_write) begin
                    r_ptr    <= r_ptr + 19'd1;
                    r_remain <= r_remain - 19'd1;
                end
                if (w_fill_end) begin
                    r_fill_busy <= 1'b0;
                    r_fill_done <= 1'b1;
                end
            end
        end
    end

    // Starve counter: counts CPU grants while a fill waits, reset by fill writes.
    always_ff @(posedge i_clk) begin
        if (i_rst || !r_fill_busy) begin
            r_starve <= '0;
        end else if (w_fill_write) begin
            r_starve <= w_grant ? LP_STARVE_ONE : '0;
        end else if (w_grant) begin
            r_starve <= r_starve + LP_STARVE_ONE;
        end
    end

    // Port mux built only from registers; idle cycles replay the last values.
    always_comb begin
        w_addra = r_port_addr;
        w_dina  = r_port_din;
        w_wea   = 1'b0;
        if (r_state == ST_CPU_ACC) begin
            w_addra = r_cpu_addr;
            w_dina  = r_cpu_wdata;
            w_wea   = r_cpu_we && w_cpu_in_range;
        end else if (w_fill_write) begin
            w_addra = r_ptr;
            w_dina  = r_fill_color;
            w_wea   = 1'b1;
        end
    end

    // Hold registers for the port address/data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_port_addr <= 19'd0;
            r_port_din  <= 8'd0;
        end else begin
            r_port_addr <= w_addra;
            r_port_din  <= w_dina;
        end
    end

    assign o_cpu_ack    = (r_state == ST_CPU_ACK);
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_fill_busy  = r_fill_busy;
    assign o_fill_done  = r_fill_done;
    assign o_vram_addra = w_addra;
    assign o_vram_dina  = w_dina;
    assign o_vram_wea   = w_wea;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_vram_port_arb.sv
// Testbench for vram_port_arb with a behavioural VRAM port A model.
module tb_vram_port_arb;

    localparam int VW = 327680;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        fill_start = 1'b0;
    logic [18:0] fill_base = '0;
    logic [18:0] fill_len = '0;
    logic [7:0]  fill_color = '0;
    logic [7:0]  vram_douta = '0;

    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        fill_busy;
    logic        fill_done;
    logic [18:0] vram_addra;
    logic [7:0]  vram_dina;
    logic        vram_wea;
    logic [2:0]  dbg_state;

    vram_port_arb dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .i_fill_start(fill_start), .i_fill_base(fill_base), .i_fill_len(fill_len),
        .i_fill_color(fill_color), .o_fill_busy(fill_busy), .o_fill_done(fill_done),
        .o_vram_addra(vram_addra), .o_vram_dina(vram_dina), .o_vram_wea(vram_wea),
        .i_vram_douta(vram_douta), .o_dbg_state(dbg_state)
    );

    // ---------------- VRAM model (1-cycle read latency) ----------------
    logic [7:0] mem [0:VW-1];
    initial for (int i = 0; i < VW; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (vram_wea && vram_addra < 19'(VW)) mem[vram_addra] <= vram_dina;
        vram_douta <= (vram_addra < 19'(VW)) ? mem[vram_addra] : 8'hEE;
    end

    // ---------------- monitor ----------------
    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
        int          cyc;
        int          acks;
    } wr_t;
    wr_t wr_log[$];
    int cyc = 0;
    int tot_acks = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (vram_wea) wr_log.push_back('{a: vram_addra, d: vram_dina, cyc: cyc, acks: tot_acks});
        if (cpu_ack) tot_acks <= tot_acks + 1;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cpu_access(input logic we, input logic [18:0] addr, input logic [7:0] wdata,
                              input logic [7:0] exp_rd, input int exp_lat, input string tag);
        int  lat;
        bit  got;
        logic [7:0] e;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        if (!we) exp_q.push_back(exp_rd);
        got = 1'b0; lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (cpu_ack) begin got = 1'b1; lat = k; end
        end
        cpu_req = 1'b0;
        check({tag, "_ack"}, 32'(got), 32'd1);
        e = 8'h00;
        if (!we) e = exp_q.pop_front();
        if (got) begin
            check({tag, "_lat"}, lat, exp_lat);
            if (!we) check({tag, "_rdata"}, 32'(cpu_rdata), 32'(e));
        end
    endtask

    // Returns the cycle number of the sampling edge's cycle.
    task automatic fill_pulse(input logic [18:0] base, input logic [18:0] len,
                              input logic [7:0] color, output int c0);
        @(negedge clk);
        fill_start = 1'b1; fill_base = base; fill_len = len; fill_color = color;
        c0 = cyc;
        @(negedge clk);
        fill_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output bit got);
        got = 1'b0; dcyc = -1;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (fill_done) begin got = 1'b1; dcyc = cyc; end
        end
    endtask

    // Writes expected at base+i in cycle c0+2+i; done one cycle after the last.
    task automatic check_fill(input string tag, input int ls0, input logic [18:0] base,
                              input int n_exp, input logic [7:0] color, input int c0,
                              input bit chk_done, input int dcyc);
        int n;
        int bad;
        wr_t e;
        n = wr_log.size() - ls0;
        bad = 0;
        check({tag, "_count"}, n, n_exp);
        for (int i = 0; i < n; i++) begin
            e = wr_log[ls0 + i];
            if (e.a !== base + 19'(i) || e.d !== color || e.cyc != c0 + 2 + i) bad++;
        end
        check({tag, "_pattern"}, bad, 0);
        if (chk_done) check({tag, "_done_cyc"}, dcyc, c0 + 2 + n_exp);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  ls0, c0, dcyc, n_sat_ack, bad, n;
        bit  got, hit, saw_done;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(cpu_ack), 0);
        check("rst_rdata", 32'(cpu_rdata), 0);
        check("rst_busy", 32'(fill_busy), 0);
        check("rst_done", 32'(fill_done), 0);
        check("rst_wea", 32'(vram_wea), 0);
        check("rst_addra", 32'(vram_addra), 0);
        check("rst_dina", 32'(vram_dina), 0);
        check("rst_state", 32'(dbg_state), 0);
        rst = 1'b0;

        // Low-bank boundary and high bank write/read
        ls0 = wr_log.size();
        cpu_access(1'b1, 19'h3FFFF, 8'hA5, 8'h00, 2, "wr_3ffff");
        cpu_access(1'b0, 19'h3FFFF, 8'h00, 8'hA5, 3, "rd_3ffff");
        cpu_access(1'b1, 19'h40000, 8'h96, 8'h00, 2, "wr_40000");
        cpu_access(1'b0, 19'h40000, 8'h00, 8'h96, 3, "rd_40000");
        @(negedge clk); #1;
        check("cpu_wr_count", wr_log.size() - ls0, 2);
        if (wr_log.size() - ls0 == 2) begin
            check("cpu_wr0", {wr_log[ls0].a, wr_log[ls0].d}, {19'h3FFFF, 8'hA5});
            check("cpu_wr1", {wr_log[ls0+1].a, wr_log[ls0+1].d}, {19'h40000, 8'h96});
        end

        // Out-of-range CPU access
        ls0 = wr_log.size();
        cpu_access(1'b1, 19'h50000, 8'h77, 8'h00, 2, "wr_50000");
        cpu_access(1'b0, 19'h50000, 8'h00, 8'h00, 3, "rd_50000");
        @(negedge clk); #1;
        check("oor_no_wea", wr_log.size() - ls0, 0);

        // Fill 0x100..0x10F, with an ignored second start mid-fill
        cpu_access(1'b1, 19'h110, 8'h11, 8'h00, 2, "wr_110");
        @(negedge clk); #1;
        ls0 = wr_log.size();
        fill_pulse(19'h100, 19'd16, 8'h3C, c0);
        check("fill_busy_rise", 32'(fill_busy), 1);
        repeat (3) @(negedge clk);
        fill_start = 1'b1; fill_base = 19'h300; fill_len = 19'd4; fill_color = 8'hFF;
        @(negedge clk);
        fill_start = 1'b0;
        wait_done(60, dcyc, got);
        check("fill16_done", 32'(got), 1);
        repeat (5) @(negedge clk); #1;
        check("fill16_busy_low", 32'(fill_busy), 0);
        check_fill("fill16", ls0, 19'h100, 16, 8'h3C, c0, 1'b1, dcyc);
        cpu_access(1'b0, 19'h10F, 8'h00, 8'h3C, 3, "rd_10f");
        cpu_access(1'b0, 19'h110, 8'h00, 8'h11, 3, "rd_110");

        // Clip at the top of VRAM
        @(negedge clk); #1;
        ls0 = wr_log.size();
        fill_pulse(19'h4FFFE, 19'd10, 8'h81, c0);
        wait_done(40, dcyc, got);
        check("clip_done", 32'(got), 1);
        @(negedge clk); #1;
        check_fill("clip", ls0, 19'h4FFFE, 2, 8'h81, c0, 1'b1, dcyc);

        // Empty fills: zero length, then out-of-range base
        for (int t = 0; t < 2; t++) begin
            @(negedge clk); #1;
            ls0 = wr_log.size();
            if (t == 0) fill_pulse(19'h400, 19'd0, 8'h12, c0);
            else        fill_pulse(19'h50000, 19'd5, 8'h12, c0);
            check("empty_busy", 32'(fill_busy), 1);
            @(negedge clk);
            check("empty_done", 32'(fill_done), 1);
            check("empty_busy_fall", 32'(fill_busy), 0);
            @(negedge clk); #1;
            check("empty_done_pulse", 32'(fill_done), 0);
            check("empty_no_write", wr_log.size() - ls0, 0);
        end

        // Fill under saturated CPU reads
        cpu_access(1'b1, 19'h10, 8'h5A, 8'h00, 2, "wr_10");
        @(negedge clk); #1;
        ls0 = wr_log.size();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h10;
        n_sat_ack = 0; got = 1'b0; bad = 0;
        for (int k = 0; k < 30000 && !got; k++) begin
            @(negedge clk);
            if (k == 3) begin
                fill_start = 1'b1; fill_base = 19'h1000; fill_len = 19'd1000; fill_color = 8'hC3;
            end
            if (k == 4) fill_start = 1'b0;
            if (cpu_ack) begin
                n_sat_ack++;
                check("sat_rdata", 32'(cpu_rdata), 32'h5A);
            end
            if (fill_done) got = 1'b1;
        end
        check("sat_done", 32'(got), 1);
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                hit = 1'b1;
                n_sat_ack++;
                check("sat_last_rdata", 32'(cpu_rdata), 32'h5A);
            end
        end
        cpu_req = 1'b0;
        check("sat_last_ack", 32'(hit), 1);
        @(negedge clk); #1;
        n = wr_log.size() - ls0;
        check("sat_fill_count", n, 1000);
        for (int i = 0; i < n; i++) begin
            if (wr_log[ls0+i].a !== 19'h1000 + 19'(i) || wr_log[ls0+i].d !== 8'hC3) bad++;
            if (i > 0 && wr_log[ls0+i].acks - wr_log[ls0+i-1].acks != 4) bad++;
        end
        check("sat_pattern_gaps", bad, 0);
        check("sat_acks_min", 32'(n_sat_ack >= 4 * 999), 1);

        // Reset mid-fill at pointer 0x120
        @(negedge clk); #1;
        ls0 = wr_log.size();
        fill_pulse(19'h118, 19'd32, 8'h44, c0);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if (vram_wea && vram_addra == 19'h120) begin
                hit = 1'b1;
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("mid_hit_120", 32'(hit), 1);
        @(negedge clk);
        check("mid_rst_ack", 32'(cpu_ack), 0);
        check("mid_rst_rdata", 32'(cpu_rdata), 0);
        check("mid_rst_busy", 32'(fill_busy), 0);
        check("mid_rst_done", 32'(fill_done), 0);
        check("mid_rst_wea", 32'(vram_wea), 0);
        check("mid_rst_addra", 32'(vram_addra), 0);
        check("mid_rst_dina", 32'(vram_dina), 0);
        check("mid_rst_state", 32'(dbg_state), 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (fill_done) saw_done = 1'b1;
        end
        #1;
        check("mid_no_done", 32'(saw_done), 0);
        check_fill("mid", ls0, 19'h118, 9, 8'h44, c0, 1'b0, 0);

        // New fill accepted after reset
        ls0 = wr_log.size();
        fill_pulse(19'h200, 19'd4, 8'h55, c0);
        wait_done(40, dcyc, got);
        check("post_done", 32'(got), 1);
        @(negedge clk); #1;
        check_fill("post", ls0, 19'h200, 4, 8'h55, c0, 1'b1, dcyc);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
